// File: rtl/config_word_loader_pkg.sv
// Shared constants for the config word loader and the LUT tile latch bank.
//   DATA_WIDTH : width of one configuration word / latch group
//   NUM_WORDS  : number of latch groups (width of the enable vector)
//   IDX_WIDTH  : width of the word index and length fields (2^IDX_WIDTH > NUM_WORDS)
//   state_t    : loader FSM state encoding {IDLE, WAIT, SETUP, STROBE, HOLD, DONE}
package config_word_loader_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned NUM_WORDS   = 40;
  localparam int unsigned IDX_WIDTH   = 6;
  localparam int unsigned STATE_WIDTH = 3;

  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_STROBE = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

endpackage

// File: rtl/config_word_loader_if.sv
// Request, word stream and latch-bank signals of the config word loader.
//   master : load requester / word source (drives start, idx, len, valid, data)
//   slave  : the loader (drives ready, data bus, enables, busy, done, err)
interface config_word_loader_if;
  import config_word_loader_pkg::*;

  logic                  io_start;
  logic [IDX_WIDTH-1:0]  io_start_idx;
  logic [IDX_WIDTH-1:0]  io_len;
  logic                  io_in_valid;
  logic [DATA_WIDTH-1:0] io_in_data;
  logic                  io_in_ready;
  logic [DATA_WIDTH-1:0] io_d_in;
  logic [NUM_WORDS-1:0]  io_configs_en;
  logic                  io_busy;
  logic                  io_done;
  logic                  io_err;

  modport master (
    output io_start, io_start_idx, io_len, io_in_valid, io_in_data,
    input  io_in_ready, io_d_in, io_configs_en, io_busy, io_done, io_err
  );

  modport slave (
    input  io_start, io_start_idx, io_len, io_in_valid, io_in_data,
    output io_in_ready, io_d_in, io_configs_en, io_busy, io_done, io_err
  );

endinterface

// File: rtl/config_onehot_decoder.sv
// Decodes a latch group index into a one-hot enable vector (all zero when en is low).
//   idx      : latch group index
//   en       : strobe qualifier
//   onehot_c : combinational one-hot enables, registered by the parent
module config_onehot_decoder
  import config_word_loader_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic                 en,
  output logic [NUM_WORDS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (en && (idx == IDX_WIDTH'(i))) onehot_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/config_word_loader.sv
// Loads the LUT tile config latch bank: each accepted word gets a setup cycle,
// a one-cycle one-hot enable strobe and a hold cycle on a registered data bus.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : request, word stream and latch bank outputs (slave side)
module config_word_loader
  import config_word_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  config_word_loader_if.slave  bus
);

  localparam int unsigned EXT_WIDTH = IDX_WIDTH + 1;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] d_in_q, d_in_d;
  logic [NUM_WORDS-1:0]  en_q, en_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [EXT_WIDTH-1:0]  end_ext_c;
  logic                  req_bad_c;

  // End of the requested range is computed one bit wider so it cannot wrap.
  always_comb begin
    end_ext_c = EXT_WIDTH'(bus.io_start_idx) + EXT_WIDTH'(bus.io_len);
    req_bad_c = (bus.io_len == '0)
             || (bus.io_start_idx >= IDX_WIDTH'(NUM_WORDS))
             || (end_ext_c > EXT_WIDTH'(NUM_WORDS));
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    d_in_d  = d_in_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.io_start) begin
          if (req_bad_c) begin
            err_d = 1'b1;
          end else begin
            idx_d   = bus.io_start_idx;
            rem_d   = bus.io_len;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.io_in_valid && ready_q) begin
          d_in_d  = bus.io_in_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        rem_d = rem_q - IDX_WIDTH'(1);
        // idx stays on the last word so it never points past the bank.
        if (rem_q == IDX_WIDTH'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_WIDTH'(1);
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  config_onehot_decoder u_decoder (
    .idx      (idx_q),
    .en       (state_d == ST_STROBE),
    .onehot_c (en_d)
  );

  // Status outputs are registered from the next state so they align with it.
  always_comb begin
    ready_d = (state_d == ST_WAIT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      d_in_q  <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      d_in_q  <= d_in_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.io_in_ready   = ready_q;
  assign bus.io_d_in       = d_in_q;
  assign bus.io_configs_en = en_q;
  assign bus.io_busy       = busy_q;
  assign bus.io_done       = done_q;
  assign bus.io_err        = err_q;

endmodule

// File: tb/tb_config_word_loader.sv
// Self-checking bench for config_word_loader: a reference model turns each load
// request into expected strobes / done / err events; a negedge monitor pops them.
module tb_config_word_loader;
  import config_word_loader_pkg::*;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } strobe_t;

  logic clk;
  logic reset;
  config_word_loader_if bus();

  config_word_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;
  int first_acc = 0;

  strobe_t     exp_q[$];
  int          exp_done_q[$];
  int          exp_err_q[$];
  logic [31:0] wq[$];

  bit          prev_strobe = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe, done and err pulse must match the next expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_strobe) begin
        chk("hold_data", 64'(bus.io_d_in), 64'(prev_data));
        chk("hold_en_zero", 64'(bus.io_configs_en), 64'd0);
      end
      prev_strobe = 1'b0;
      if (bus.io_configs_en != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'(bus.io_configs_en), 64'd0);
        end else begin
          strobe_t e;
          logic [NUM_WORDS-1:0] oh;
          e  = exp_q.pop_front();
          oh = NUM_WORDS'(1) << e.idx;
          chk("strobe_en", 64'(bus.io_configs_en), 64'(oh));
          chk("strobe_data", 64'(bus.io_d_in), 64'(e.data));
          prev_strobe = 1'b1;
          prev_data   = e.data;
        end
      end
      if (bus.io_done) begin
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          void'(exp_done_q.pop_front());
          chk("done_after_all_strobes", 64'(exp_q.size()), 64'd0);
        end
      end
      if (bus.io_err) begin
        if (exp_err_q.size() == 0) begin
          chk("unexpected_err", 64'd1, 64'd0);
        end else begin
          void'(exp_err_q.pop_front());
          chk("err_busy_low", 64'(bus.io_busy), 64'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a request is either rejected or writes words to sidx..sidx+len-1.
  function automatic bit model_request(input int sidx, input int len);
    if (len == 0 || sidx >= int'(NUM_WORDS) || sidx + len > int'(NUM_WORDS)) begin
      exp_err_q.push_back(1);
      return 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      strobe_t e;
      e.idx  = sidx + i;
      e.data = wq[i];
      exp_q.push_back(e);
    end
    exp_done_q.push_back(1);
    return 1'b1;
  endfunction

  task automatic issue_start(input int sidx, input int len);
    bus.io_start     = 1'b1;
    bus.io_start_idx = IDX_WIDTH'(sidx);
    bus.io_len       = IDX_WIDTH'(len);
    step();
    bus.io_start     = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] w, input int gap, output int acc_cyc);
    bit acc;
    int n;
    for (int g = 0; g < gap; g++) begin
      bus.io_in_valid = 1'b0;
      step();
    end
    bus.io_in_valid = 1'b1;
    bus.io_in_data  = w;
    n = 0;
    do begin
      acc = bus.io_in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'd1, 64'd0);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.io_busy && n < 200) begin
      step();
      n++;
    end
    if (bus.io_busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Full request: model, start, feed words from wq, wait for completion.
  task automatic run_load(input int sidx, input int len, input bit hold_valid, input int max_gap);
    int acc;
    if (!model_request(sidx, len)) begin
      issue_start(sidx, len);
      for (int k = 0; k < 3; k++) begin
        chk("reject_busy", 64'(bus.io_busy), 64'd0);
        chk("reject_en", 64'(bus.io_configs_en), 64'd0);
        step();
      end
      return;
    end
    issue_start(sidx, len);
    for (int i = 0; i < len; i++) begin
      feed_word(wq[i], hold_valid ? 0 : int'($urandom_range(0, max_gap)), acc);
      if (i == 0) first_acc = acc;
    end
    bus.io_in_valid = 1'b0;
    wait_idle();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.io_start     = 1'b0;
    bus.io_start_idx = '0;
    bus.io_len       = '0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_data   = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (3) step();

    chk("rst_d_in", 64'(bus.io_d_in), 64'd0);
    chk("rst_en", 64'(bus.io_configs_en), 64'd0);
    chk("rst_ready", 64'(bus.io_in_ready), 64'd0);
    chk("rst_busy", 64'(bus.io_busy), 64'd0);
    chk("rst_done", 64'(bus.io_done), 64'd0);
    chk("rst_err", 64'(bus.io_err), 64'd0);
    reset = 1'b0;
    step();

    // Full load, valid held high.
    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back(32'hA500_0000 + 32'(i));
    run_load(0, 40, 1'b1, 0);
    // Acceptance cycle t ends at edge first_acc; done is high in cycle t+160,
    // which is the cycle starting at edge first_acc+159.
    chk("done_latency", 64'(done_cyc - first_acc), 64'd159);

    // Partial load up to the last word.
    wq.delete();
    wq.push_back(32'h1); wq.push_back(32'h2); wq.push_back(32'h3);
    run_load(37, 3, 1'b1, 0);

    // Rejected requests.
    run_load(0, 0, 1'b0, 0);
    run_load(38, 3, 1'b0, 0);
    run_load(40, 1, 1'b0, 0);

    // Backpressure with a stray start in the middle.
    wq.delete();
    wq.push_back($urandom); wq.push_back($urandom);
    void'(model_request(10, 2));
    issue_start(10, 2);
    for (int k = 0; k < 10; k++) begin
      chk("bp_ready", 64'(bus.io_in_ready), 64'd1);
      chk("bp_en", 64'(bus.io_configs_en), 64'd0);
      step();
    end
    bus.io_start     = 1'b1;
    bus.io_start_idx = IDX_WIDTH'(0);
    bus.io_len       = IDX_WIDTH'(1);
    step();
    bus.io_start = 1'b0;
    chk("bp_still_busy", 64'(bus.io_busy), 64'd1);
    feed_word(wq[0], 0, acc);
    feed_word(wq[1], 2, acc);
    bus.io_in_valid = 1'b0;
    wait_idle();
    step();

    // Async reset during the strobe of word 5 of a full load.
    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back($urandom);
    void'(model_request(0, 40));
    issue_start(0, 40);
    for (int i = 0; i < 6; i++) feed_word(wq[i], 0, acc);
    bus.io_in_valid = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (bus.io_configs_en == '0 && n < 10);
    end
    chk("strobe5_seen", 64'(bus.io_configs_en[5]), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_en", 64'(bus.io_configs_en), 64'd0);
    chk("arst_busy", 64'(bus.io_busy), 64'd0);
    exp_q.delete();
    exp_done_q.delete();
    prev_strobe = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    wq.delete();
    wq.push_back(32'hC0FF_EE05);
    run_load(5, 1, 1'b0, 0);

    // Randomized requests, some invalid, random valid gaps.
    for (int r = 0; r < 16; r++) begin
      int sidx;
      int len;
      sidx = int'($urandom_range(0, 44));
      len  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back($urandom);
      run_load(sidx, len, 1'b0, 3);
    end

    repeat (3) step();
    chk("strobes_left", 64'(exp_q.size()), 64'd0);
    chk("dones_left", 64'(exp_done_q.size()), 64'd0);
    chk("errs_left", 64'(exp_err_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_word_loader.md
Name: config_word_loader

Overview:
- Sequencer that loads the configuration latch bank of a LUT tile.
- Accepts 32-bit configuration words over a valid/ready stream and drives a stable data bus plus one-hot, glitch-free latch enables into the config latch bank (40 words, 1280 bits).
- Each word gets a setup cycle, a one-cycle enable strobe and a hold cycle, so the level-sensitive latches capture stable data.
- Supports full or partial reload: start index plus word count.

Parameters:
- DATA_WIDTH, 32, width of one configuration word / latch group
- NUM_WORDS, 40, number of latch groups (width of the enable vector)
- IDX_WIDTH, 6, width of word index and length fields; must satisfy 2^IDX_WIDTH > NUM_WORDS

Ports:
- clk  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- io_start  input  1  one-cycle request to begin a load; sampled only in IDLE
- io_start_idx  input  IDX_WIDTH  first latch group to write; sampled with io_start
- io_len  input  IDX_WIDTH  number of words to write; sampled with io_start
- io_in_valid  input  1  a word is presented on io_in_data
- io_in_data  input  DATA_WIDTH  configuration word
- io_in_ready  output  1  loader accepts a word this cycle
- io_d_in  output  DATA_WIDTH  registered data bus to the latch bank
- io_configs_en  output  NUM_WORDS  registered one-hot (or zero) latch enables
- io_busy  output  1  high in every state except IDLE
- io_done  output  1  one-cycle pulse when the last word's hold cycle completes
- io_err  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (async) forces:
  - state IDLE; idx 0; remaining 0
  - io_d_in 0; io_configs_en 0
  - io_in_ready 0; io_busy 0; io_done 0; io_err 0
- All outputs are driven from flops; no combinational path from any input to io_configs_en.
- States and transitions:
  - IDLE: io_start high checks the request.
    - io_len==0, or io_start_idx>=NUM_WORDS, or io_start_idx+io_len>NUM_WORDS (computed at IDX_WIDTH+1 bits): pulse io_err next cycle, stay IDLE.
    - Otherwise: load idx=io_start_idx and remaining=io_len, go to WAIT.
  - WAIT: io_in_ready=1. On io_in_valid&&io_in_ready, register io_in_data into io_d_in, go to SETUP.
  - SETUP: one cycle with io_d_in stable and io_configs_en=0. Go to STROBE.
  - STROBE: io_configs_en has only bit[idx] set, for exactly one cycle. Go to HOLD.
  - HOLD: io_configs_en=0; io_d_in unchanged. Decrement remaining and increment idx.
    - If remaining was 1: go to DONE.
    - Otherwise: go to WAIT.
  - DONE: io_done=1 for one cycle, then IDLE.
- Latency: a word accepted at cycle t gives io_d_in valid at t+1, enable high during t+2, enable low at t+3. The next acceptance is possible at t+4, so throughput is 1 word per 4 cycles.
- io_d_in changes only on acceptance in WAIT. It holds its last value in IDLE/DONE and is not cleared.
- io_in_ready is 0 in all states except WAIT. Valid in any other state is ignored and the word is not consumed.
- io_start in any state other than IDLE is ignored; no io_err is raised.
- Upper boundary: idx never exceeds NUM_WORDS-1 (guaranteed by the start check). A load ending at word NUM_WORDS-1 finishes normally.
- Reset mid-load (including during STROBE): io_configs_en drops to 0 immediately. Latch contents already written are retained by the latch bank, and the partial load is abandoned.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, WAIT, SETUP, STROBE, HOLD, DONE}
  - DATA_WIDTH, NUM_WORDS and IDX_WIDTH constants, shared with the latch bank so widths agree
- One natural sub-module: config_onehot_decoder (idx, enable → NUM_WORDS one-hot vector), registered in the parent.

Test Plan:
- Reset then full load:
  - Stimulus: start_idx=0, len=40, words 0xA5000000+i, with valid held high.
  - Required: each io_configs_en bit pulses exactly once, in order 0..39, one cycle each, with io_d_in equal to the matching word in the surrounding SETUP/STROBE/HOLD cycles.
  - Required: io_done pulses once, 160 cycles after the first acceptance.
- Partial load:
  - Stimulus: start_idx=37, len=3, words 0x1, 0x2, 0x3.
  - Required: en[37], en[38], en[39] strobe with the matching data; no other enable bit is ever high.
- Rejects:
  - Stimulus: start with len=0; separately start_idx=38 with len=3; separately start_idx=40 with len=1.
  - Required: each gives an io_err pulse, io_busy stays 0, and io_configs_en stays 0.
- Backpressure:
  - Stimulus: len=2, with io_in_valid low for 10 cycles in WAIT.
  - Required: state holds with io_in_ready=1 and io_configs_en=0; a start pulse during the load produces no io_err and no restart.
- Async reset during the STROBE of word 5 of a full load:
  - Required: io_configs_en=0 and io_busy=0 in the same cycle, before the next clk edge.
  - Required: a following start_idx=5, len=1 load writes only en[5].
